// File: rtl/sddr_pkg.sv
// -----------------------------------------------------------------------------
// sddr_pkg
// Shared types and constants for the single-line write-back buffer:
//   - state_e          : line buffer FSM states
//   - WORD_* / BYTE_*  : word and byte geometry of the CPU port
//   - line_offset_bits : byte-offset width of a line (log2 of bytes per line)
// -----------------------------------------------------------------------------
package sddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_CMD,
    ST_FILL_CMD,
    ST_FILL_WAIT,
    ST_FLUSH_END
  } state_e;

  localparam int WORD_BITS  = 32;
  localparam int BYTE_BITS  = 8;
  localparam int WORD_BYTES = WORD_BITS / BYTE_BITS;
  // Address bits that select a byte inside a word (ignored by the buffer).
  localparam int WORD_OFS   = 2;

  // Number of address bits that select a byte inside a line.
  function automatic int line_offset_bits(input int line_bits);
    return $clog2(line_bits / BYTE_BITS);
  endfunction

endpackage

// File: rtl/sddr_word_merge.sv
// -----------------------------------------------------------------------------
// sddr_word_merge
// Combinational byte-masked insertion of one 32-bit word into a line.
//   line_i       : source line
//   word_index_i : word slot w; the word lives in line[32w+31:32w]
//   mask_i       : byte enables; byte b is replaced when mask_i[b] is set
//   data_i       : word to insert
//   line_o       : source line with the enabled bytes replaced
//   word_o       : the resulting word at slot w (the plain read when mask is 0)
// -----------------------------------------------------------------------------
module sddr_word_merge
  import sddr_pkg::*;
#(
  parameter int LINE_BITS = 128,
  parameter int IDX_BITS  = 2
) (
  input  logic [LINE_BITS-1:0]  line_i,
  input  logic [IDX_BITS-1:0]   word_index_i,
  input  logic [WORD_BYTES-1:0] mask_i,
  input  logic [WORD_BITS-1:0]  data_i,
  output logic [LINE_BITS-1:0]  line_o,
  output logic [WORD_BITS-1:0]  word_o
);

  localparam int NUM_WORDS = LINE_BITS / WORD_BITS;

  // NOTE: every output gets a default before the loop, so no path leaves a
  // combinational output unassigned and no latch is inferred.
  always_comb begin
    line_o = line_i;
    word_o = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (word_index_i == IDX_BITS'(w)) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (mask_i[b]) begin
            line_o[w*WORD_BITS + b*BYTE_BITS +: BYTE_BITS] = data_i[b*BYTE_BITS +: BYTE_BITS];
          end
        end
        word_o = line_o[w*WORD_BITS +: WORD_BITS];
      end
    end
  end

endmodule

// File: rtl/sddr_line_buffer.sv
// -----------------------------------------------------------------------------
// sddr_line_buffer
// Single-line write-back buffer between the CPU load/store port and the DDR
// controller's whole-line burst interface. Masked 32-bit stores become
// read-modify-write in a local line register because the controller has no
// data mask.
//
// Ports (all synchronous to cpu_clock_i; reset_i is synchronous active-high):
//   req_valid_i / req_ack_o      CPU request handshake (transfer on both high)
//   req_address_i                byte address, bits [1:0] ignored
//   req_write_i/req_mask_i/req_data_i  store flag, byte enables, store data
//   rsp_valid_o / rsp_data_o     one-cycle completion pulse and word
//   flush_i / flush_done_o       write back + invalidate, completion pulse
//   ddr_cmd_*                    registered burst command to the controller
//   ddr_rsp_ready_i/ddr_rsp_data_i  read-line return pulse and data
// -----------------------------------------------------------------------------
module sddr_line_buffer
  import sddr_pkg::*;
#(
  parameter int ADDRESS_BITS = 27,
  parameter int LINE_BITS    = 128
) (
  input  logic                    cpu_clock_i,
  input  logic                    reset_i,
  input  logic                    req_valid_i,
  output logic                    req_ack_o,
  input  logic [ADDRESS_BITS-1:0] req_address_i,
  input  logic                    req_write_i,
  input  logic [WORD_BYTES-1:0]   req_mask_i,
  input  logic [WORD_BITS-1:0]    req_data_i,
  output logic                    rsp_valid_o,
  output logic [WORD_BITS-1:0]    rsp_data_o,
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic                    ddr_cmd_valid_o,
  input  logic                    ddr_cmd_ack_i,
  output logic [ADDRESS_BITS-1:0] ddr_cmd_address_o,
  output logic                    ddr_cmd_write_o,
  output logic [LINE_BITS-1:0]    ddr_cmd_data_o,
  input  logic                    ddr_rsp_ready_i,
  input  logic [LINE_BITS-1:0]    ddr_rsp_data_i
);

  localparam int OFS      = line_offset_bits(LINE_BITS);
  localparam int TAG_BITS = ADDRESS_BITS - OFS;
  localparam int IDX_BITS = OFS - WORD_OFS;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [LINE_BITS-1:0]    line_q, line_d;
  logic [TAG_BITS-1:0]     tag_q, tag_d;
  logic                    line_valid_q, line_valid_d;
  logic                    dirty_q, dirty_d;
  logic                    flushing_q, flushing_d;

  // Pending miss request, held while the line is written back / refilled.
  logic [TAG_BITS-1:0]     pend_tag_q, pend_tag_d;
  logic [IDX_BITS-1:0]     pend_idx_q, pend_idx_d;
  logic                    pend_write_q, pend_write_d;
  logic [WORD_BYTES-1:0]   pend_mask_q, pend_mask_d;
  logic [WORD_BITS-1:0]    pend_data_q, pend_data_d;

  // Registered outputs.
  logic                    rsp_valid_q, rsp_valid_d;
  logic [WORD_BITS-1:0]    rsp_data_q, rsp_data_d;
  logic                    flush_done_q, flush_done_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic                    cmd_write_q, cmd_write_d;
  logic [ADDRESS_BITS-1:0] cmd_address_q, cmd_address_d;
  logic [LINE_BITS-1:0]    cmd_data_q, cmd_data_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic                hit;
  logic                req_fire;
  logic                unused_byte_bits;

  assign req_tag  = req_address_i[ADDRESS_BITS-1:OFS];
  assign req_idx  = req_address_i[OFS-1:WORD_OFS];
  assign hit      = line_valid_q && (tag_q == req_tag);
  // Byte-within-word address bits carry no meaning for word accesses.
  assign unused_byte_bits = ^req_address_i[WORD_OFS-1:0];

  // Acceptance is combinational on flush_i so a simultaneous flush wins.
  assign req_ack_o = !reset_i && (state_q == ST_IDLE) && !flush_i;
  assign req_fire  = req_valid_i && req_ack_o;

  // ---------------------------------------------------------------------------
  // Shared merge unit: the hit path merges into the resident line, the fill
  // path merges the pending store into the line returned by the controller.
  // A load uses mask 0, which makes the merge a plain word read.
  // ---------------------------------------------------------------------------
  logic [LINE_BITS-1:0]  merge_line_in, merge_line_out;
  logic [IDX_BITS-1:0]   merge_idx;
  logic [WORD_BYTES-1:0] merge_mask;
  logic [WORD_BITS-1:0]  merge_data, merge_word;

  always_comb begin
    if (state_q == ST_FILL_WAIT) begin
      merge_line_in = ddr_rsp_data_i;
      merge_idx     = pend_idx_q;
      merge_mask    = pend_write_q ? pend_mask_q : '0;
      merge_data    = pend_data_q;
    end else begin
      merge_line_in = line_q;
      merge_idx     = req_idx;
      merge_mask    = req_write_i ? req_mask_i : '0;
      merge_data    = req_data_i;
    end
  end

  sddr_word_merge #(
    .LINE_BITS (LINE_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_word_merge (
    .line_i       (merge_line_in),
    .word_index_i (merge_idx),
    .mask_i       (merge_mask),
    .data_i       (merge_data),
    .line_o       (merge_line_out),
    .word_o       (merge_word)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    tag_d         = tag_q;
    line_valid_d  = line_valid_q;
    dirty_d       = dirty_q;
    flushing_d    = flushing_q;
    pend_tag_d    = pend_tag_q;
    pend_idx_d    = pend_idx_q;
    pend_write_d  = pend_write_q;
    pend_mask_d   = pend_mask_q;
    pend_data_d   = pend_data_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    flush_done_d  = 1'b0;
    cmd_valid_d   = cmd_valid_q;
    cmd_write_d   = cmd_write_q;
    cmd_address_d = cmd_address_q;
    cmd_data_d    = cmd_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          flushing_d = 1'b1;
          if (line_valid_q && dirty_q) begin
            state_d       = ST_WB_CMD;
            cmd_valid_d   = 1'b1;
            cmd_write_d   = 1'b1;
            cmd_address_d = {tag_q, {OFS{1'b0}}};
            cmd_data_d    = line_q;
          end else begin
            state_d = ST_FLUSH_END;
          end
        end else if (req_fire) begin
          if (hit) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = merge_word;
            if (req_write_i && (req_mask_i != '0)) begin
              line_d  = merge_line_out;
              dirty_d = 1'b1;
            end
          end else begin
            pend_tag_d   = req_tag;
            pend_idx_d   = req_idx;
            pend_write_d = req_write_i;
            pend_mask_d  = req_mask_i;
            pend_data_d  = req_data_i;
            cmd_valid_d  = 1'b1;
            if (line_valid_q && dirty_q) begin
              state_d       = ST_WB_CMD;
              cmd_write_d   = 1'b1;
              cmd_address_d = {tag_q, {OFS{1'b0}}};
              cmd_data_d    = line_q;
            end else begin
              state_d       = ST_FILL_CMD;
              cmd_write_d   = 1'b0;
              cmd_address_d = {req_tag, {OFS{1'b0}}};
            end
          end
        end
      end

      // The controller sends no write response; the fill command that follows
      // is ordered behind the write by its single command path.
      ST_WB_CMD: begin
        if (ddr_cmd_ack_i) begin
          dirty_d = 1'b0;
          if (flushing_q) begin
            state_d     = ST_FLUSH_END;
            cmd_valid_d = 1'b0;
          end else begin
            state_d       = ST_FILL_CMD;
            cmd_valid_d   = 1'b1;
            cmd_write_d   = 1'b0;
            cmd_address_d = {pend_tag_q, {OFS{1'b0}}};
          end
        end
      end

      ST_FILL_CMD: begin
        if (ddr_cmd_ack_i) begin
          state_d     = ST_FILL_WAIT;
          cmd_valid_d = 1'b0;
        end
      end

      ST_FILL_WAIT: begin
        if (ddr_rsp_ready_i) begin
          state_d      = ST_IDLE;
          line_d       = merge_line_out;
          tag_d        = pend_tag_q;
          line_valid_d = 1'b1;
          dirty_d      = pend_write_q && (pend_mask_q != '0);
          rsp_valid_d  = 1'b1;
          rsp_data_d   = merge_word;
        end
      end

      ST_FLUSH_END: begin
        state_d      = ST_IDLE;
        line_valid_d = 1'b0;
        dirty_d      = 1'b0;
        flushing_d   = 1'b0;
        flush_done_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge cpu_clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      line_valid_q  <= 1'b0;
      dirty_q       <= 1'b0;
      flushing_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      flush_done_q  <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_address_q <= '0;
      cmd_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      line_valid_q  <= line_valid_d;
      dirty_q       <= dirty_d;
      flushing_q    <= flushing_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      flush_done_q  <= flush_done_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_write_q   <= cmd_write_d;
      cmd_address_q <= cmd_address_d;
      cmd_data_q    <= cmd_data_d;
    end
  end

  // NOTE: the line, tag and pending request are datapath storage qualified by
  // line_valid_q and the FSM state, so they carry no reset.
  always_ff @(posedge cpu_clock_i) begin
    line_q       <= line_d;
    tag_q        <= tag_d;
    pend_tag_q   <= pend_tag_d;
    pend_idx_q   <= pend_idx_d;
    pend_write_q <= pend_write_d;
    pend_mask_q  <= pend_mask_d;
    pend_data_q  <= pend_data_d;
  end

  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_data_o        = rsp_data_q;
  assign flush_done_o      = flush_done_q;
  assign ddr_cmd_valid_o   = cmd_valid_q;
  assign ddr_cmd_write_o   = cmd_write_q;
  assign ddr_cmd_address_o = cmd_address_q;
  assign ddr_cmd_data_o    = cmd_data_q;

endmodule
